pong_game_ctrl: RTL

Top-level Pong game sequencer. Gates the ball controller through o_Game_Active and watches ball position against both paddles to detect misses. Keeps per-player scores, inserts a serve delay after each point and declares a winner at the score limit. Sits between the button/debounce logic and the ball/paddle controllers; its scores feed the score display.

---
 rtl/pong_game_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong match sequencer.
// Serve gating, paddle-miss detection, scoring and winner.
module pong_game_ctrl #(
  parameter int c_GAME_WIDTH    = 40,
  parameter int c_GAME_HEIGHT   = 30,
  parameter int c_PADDLE_HEIGHT = 6,
  parameter int c_SCORE_LIMIT   = 9,
  parameter int c_SERVE_DELAY   = 25000000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Start,
  input  logic [$clog2(c_GAME_WIDTH)-1:0] i_Ball_X,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Ball_Y,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Paddle_Y_P1,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Paddle_Y_P2,
  output logic o_Game_Active,
  output logic [$clog2(c_SCORE_LIMIT+1)-1:0] o_P1_Score,
  output logic [$clog2(c_SCORE_LIMIT+1)-1:0] o_P2_Score,
  output logic o_Point_Pulse,
  output logic o_Game_Over,
  output logic o_Winner
);

  localparam int XW = $clog2(c_GAME_WIDTH);
  localparam int YW = $clog2(c_GAME_HEIGHT);
  localparam int SW = $clog2(c_SCORE_LIMIT + 1);
  localparam int CW = $clog2(c_SERVE_DELAY + 1);

  localparam logic [XW-1:0] RIGHT_COL =
    XW'(c_GAME_WIDTH - 1);
  localparam logic [YW:0] PAD_SPAN =
    (YW + 1)'(c_PADDLE_HEIGHT - 1);
  localparam logic [SW-1:0] LIMIT =
    SW'(c_SCORE_LIMIT);
  localparam logic [CW-1:0] SERVE_LAST =
    CW'(c_SERVE_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RUNNING    = 3'd1,
    P1_POINT   = 3'd2,
    P2_POINT   = 3'd3,
    SERVE_WAIT = 3'd4,
    GAME_OVER  = 3'd5
  } state_t;

  state_t        state;
  logic          start_q;
  logic          start_evt;
  logic [CW-1:0] serve_cnt;

  // One extra bit so a paddle near the bottom edge
  // cannot wrap its lower bound back to the top.
  logic [YW:0]   ball_y;
  logic [YW:0]   top1;
  logic [YW:0]   top2;
  logic [YW:0]   bot1;
  logic [YW:0]   bot2;
  logic          p1_miss;
  logic          p2_miss;
  logic [SW-1:0] p1_next;
  logic [SW-1:0] p2_next;

  assign ball_y  = {1'b0, i_Ball_Y};
  assign top1    = {1'b0, i_Paddle_Y_P1};
  assign top2    = {1'b0, i_Paddle_Y_P2};
  assign bot1    = top1 + PAD_SPAN;
  assign bot2    = top2 + PAD_SPAN;

  assign p1_miss = (i_Ball_X == '0) &&
                   ((ball_y < top1) || (ball_y > bot1));
  assign p2_miss = (i_Ball_X == RIGHT_COL) &&
                   ((ball_y < top2) || (ball_y > bot2));

  assign p1_next = o_P1_Score + SW'(1);
  assign p2_next = o_P2_Score + SW'(1);

  // Start rising-edge detect, event registered once more.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      start_q   <= 1'b0;
      start_evt <= 1'b0;
    end else begin
      start_q   <= i_Start;
      start_evt <= i_Start & ~start_q;
    end
  end

  // Game sequencer with registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= IDLE;
      serve_cnt     <= '0;
      o_Game_Active <= 1'b0;
      o_P1_Score    <= '0;
      o_P2_Score    <= '0;
      o_Point_Pulse <= 1'b0;
      o_Game_Over   <= 1'b0;
      o_Winner      <= 1'b0;
    end else begin
      o_Point_Pulse <= 1'b0;
      case (state)
        IDLE: begin
          o_Game_Active <= 1'b0;
          if (start_evt) begin
            state         <= RUNNING;
            o_Game_Active <= 1'b1;
            o_P1_Score    <= '0;
            o_P2_Score    <= '0;
          end
        end
        RUNNING: begin
          if (p1_miss) begin
            state         <= P2_POINT;
            o_Game_Active <= 1'b0;
          end else if (p2_miss) begin
            state         <= P1_POINT;
            o_Game_Active <= 1'b0;
          end
        end
        P1_POINT: begin
          o_P1_Score    <= p1_next;
          o_Point_Pulse <= 1'b1;
          if (p1_next == LIMIT) begin
            state       <= GAME_OVER;
            o_Game_Over <= 1'b1;
            o_Winner    <= 1'b0;
          end else begin
            state     <= SERVE_WAIT;
            serve_cnt <= '0;
          end
        end
        P2_POINT: begin
          o_P2_Score    <= p2_next;
          o_Point_Pulse <= 1'b1;
          if (p2_next == LIMIT) begin
            state       <= GAME_OVER;
            o_Game_Over <= 1'b1;
            o_Winner    <= 1'b1;
          end else begin
            state     <= SERVE_WAIT;
            serve_cnt <= '0;
          end
        end
        SERVE_WAIT: begin
          if (serve_cnt == SERVE_LAST) begin
            state         <= RUNNING;
            o_Game_Active <= 1'b1;
          end else begin
            serve_cnt <= serve_cnt + CW'(1);
          end
        end
        GAME_OVER: begin
          if (start_evt) begin
            state         <= RUNNING;
            o_Game_Active <= 1'b1;
            o_P1_Score    <= '0;
            o_P2_Score    <= '0;
            o_Game_Over   <= 1'b0;
            o_Winner      <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          o_Game_Active <= 1'b0;
          o_Game_Over   <= 1'b0;
          o_Winner      <= 1'b0;
        end
      endcase
    end
  end

endmodule
